// File: rtl/wb_regfile_pkg.sv
// ============================================================================
//  wb_regfile_pkg : shared sizes and defaults for the WB register file slice
//  Revision 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;
    localparam int              REG_CNT    = 32;
    localparam int              REG_AW     = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
    localparam int              DEF_DATA_W = 32;
    localparam int              DEF_PEND_W = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

`default_nettype wire

// File: rtl/wb_pend_counter.sv
// ============================================================================
//  wb_pend_counter : saturating up/down count of in-flight writes to one reg
//  Revision 1.0
// ============================================================================
`default_nettype none

module wb_pend_counter
    import wb_regfile_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o
);

    localparam logic [PEND_W-1:0] C_MAX = '1;

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; the ends never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
//  wb_regfile : 32x32 register file, WB write port, bypassed ID read ports,
//               pending-write scoreboard driving IDStall
//  Revision 1.0
// ============================================================================
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              RegClk,
    input  logic              RegRstN,
    input  logic [4:0]        WBRd,
    input  logic [DATA_W-1:0] WBData,
    input  logic              WBRegWrite,
    input  logic [4:0]        IDRs,
    input  logic [4:0]        IDRt,
    output logic [DATA_W-1:0] IDRsData,
    output logic [DATA_W-1:0] IDRtData,
    input  logic              IDIssue,
    input  logic [4:0]        IDIssueRd,
    output logic              IDStall
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] reg_q [REG_CNT];
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [PEND_W-1:0] cnt_w [REG_CNT];
    logic [REG_CNT-1:1] inc_w;
    logic [REG_CNT-1:1] dec_w;

    logic wb_we_w;
    logic hz_rs_w;
    logic hz_rt_w;
    logic full_w;
    logic issue_ok_w;

    assign wb_we_w = WBRegWrite && (WBRd != ZERO_REG);

    // ------------------------------------------------------------------
    // Storage; r0 stays zero because writes to it are filtered above.
    // ------------------------------------------------------------------
    always_ff @(posedge RegClk or negedge RegRstN) begin
        if (!RegRstN) begin
            for (int i = 0; i < REG_CNT; i++) begin
                reg_q[i] <= '0;
            end
        end else if (wb_we_w) begin
            reg_q[WBRd] <= WBData;
        end
    end

    // Same-edge write-through so ID never captures a stale value.
    always_comb begin
        rs_data_d = reg_q[IDRs];
        rt_data_d = reg_q[IDRt];
        if (wb_we_w && (WBRd == IDRs)) begin
            rs_data_d = WBData;
        end
        if (wb_we_w && (WBRd == IDRt)) begin
            rt_data_d = WBData;
        end
    end

    always_ff @(posedge RegClk or negedge RegRstN) begin
        if (!RegRstN) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else begin
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
        end
    end

    assign IDRsData = rs_data_q;
    assign IDRtData = rt_data_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    assign cnt_w[0] = '0;

    for (genvar g = 1; g < REG_CNT; g++) begin : g_pend
        assign inc_w[g] = issue_ok_w && (IDIssueRd == REG_AW'(g));
        assign dec_w[g] = WBRegWrite && (WBRd == REG_AW'(g));

        wb_pend_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk_i  (RegClk),
            .rst_ni (RegRstN),
            .inc_i  (inc_w[g]),
            .dec_i  (dec_w[g]),
            .cnt_o  (cnt_w[g])
        );
    end

    // A single outstanding write that lands this cycle is covered by bypass.
    always_comb begin
        hz_rs_w = (IDRs != ZERO_REG) && (cnt_w[IDRs] != '0)
                  && !((cnt_w[IDRs] == CNT_ONE) && WBRegWrite && (WBRd == IDRs));
        hz_rt_w = (IDRt != ZERO_REG) && (cnt_w[IDRt] != '0)
                  && !((cnt_w[IDRt] == CNT_ONE) && WBRegWrite && (WBRd == IDRt));
        full_w  = IDIssue && (IDIssueRd != ZERO_REG) && (cnt_w[IDIssueRd] == CNT_MAX);
    end

    assign IDStall    = hz_rs_w || hz_rt_w || full_w;
    assign issue_ok_w = IDIssue && !IDStall;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
//  tb_wb_regfile : directed bench with a behavioural register-file model
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    localparam int DATA_W  = 32;
    localparam int PEND_W  = 2;
    localparam int MAX_CNT = (2 ** PEND_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        WBRd;
    logic [DATA_W-1:0] WBData;
    logic              WBRegWrite;
    logic [4:0]        IDRs;
    logic [4:0]        IDRt;
    logic [DATA_W-1:0] IDRsData;
    logic [DATA_W-1:0] IDRtData;
    logic              IDIssue;
    logic [4:0]        IDIssueRd;
    logic              IDStall;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DATA_W), .PEND_W(PEND_W)) dut (
        .RegClk     (clk),
        .RegRstN    (rst_n),
        .WBRd       (WBRd),
        .WBData     (WBData),
        .WBRegWrite (WBRegWrite),
        .IDRs       (IDRs),
        .IDRt       (IDRt),
        .IDRsData   (IDRsData),
        .IDRtData   (IDRtData),
        .IDIssue    (IDIssue),
        .IDIssueRd  (IDIssueRd),
        .IDStall    (IDStall)
    );

    // ------------------------------------------------------------------
    // Model: plain integer pending counts and a data array.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] m_reg [32];
    int                m_cnt [32];
    logic [DATA_W-1:0] m_rs;
    logic [DATA_W-1:0] m_rt;

    function automatic bit m_hazard(input logic [4:0] x);
        if (x == 0 || m_cnt[x] == 0) return 1'b0;
        if (m_cnt[x] == 1 && WBRegWrite && WBRd == x) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit full;
        full = IDIssue && IDIssueRd != 0 && m_cnt[IDIssueRd] == MAX_CNT;
        return m_hazard(IDRs) || m_hazard(IDRt) || full;
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (WBRegWrite && WBRd == a) return WBData;
        return m_reg[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] <= '0;
                m_cnt[i] <= 0;
            end
            m_rs <= '0;
            m_rt <= '0;
        end else begin
            m_rs <= m_read(IDRs);
            m_rt <= m_read(IDRt);
            if (WBRegWrite && WBRd != 0) m_reg[WBRd] <= WBData;
            for (int r = 1; r < 32; r++) begin
                m_cnt[r] <= m_cnt[r]
                    + ((IDIssue && !m_stall() && IDIssueRd == r) ? 1 : 0)
                    - ((WBRegWrite && WBRd == r && m_cnt[r] != 0) ? 1 : 0);
            end
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_rs_data", IDRsData, m_rs);
            check("cmp_rt_data", IDRtData, m_rt);
            check("cmp_stall", {31'b0, IDStall}, {31'b0, m_stall()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WBRd = '0; WBData = '0; WBRegWrite = 1'b0;
        IDRs = '0; IDRt = '0; IDIssue = 1'b0; IDIssueRd = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset state read-out
        IDRs = 5'd5; IDRt = 5'd31;
        tick();
        check("reset_rs", IDRsData, 32'h0);
        check("reset_rt", IDRtData, 32'h0);
        check("reset_stall", {31'b0, IDStall}, 32'h0);

        // Same-edge bypass then stored value
        WBRegWrite = 1'b1; WBRd = 5'd3; WBData = 32'hDEADBEEF; IDRs = 5'd3;
        tick();
        check("bypass_rs", IDRsData, 32'hDEADBEEF);
        WBRegWrite = 1'b0;
        tick();
        check("stored_rs", IDRsData, 32'hDEADBEEF);

        // r0 is hardwired; issue to r0 never stalls
        WBRegWrite = 1'b1; WBRd = 5'd0; WBData = 32'hFFFFFFFF; IDRs = 5'd0;
        IDIssue = 1'b1; IDIssueRd = 5'd0;
        #1 check("r0_issue_stall", {31'b0, IDStall}, 32'h0);
        tick();
        check("r0_read", IDRsData, 32'h0);
        tick();
        check("r0_issue_stall2", {31'b0, IDStall}, 32'h0);
        idle_inputs();

        // RAW hazard on r7 cleared by last-write bypass
        IDIssue = 1'b1; IDIssueRd = 5'd7;
        tick();
        IDIssue = 1'b0; IDRt = 5'd7;
        #1 check("raw_stall", {31'b0, IDStall}, 32'h1);
        WBRegWrite = 1'b1; WBRd = 5'd7; WBData = 32'h12;
        #1 check("raw_clear", {31'b0, IDStall}, 32'h0);
        tick();
        check("raw_rt_data", IDRtData, 32'h12);
        idle_inputs();

        // Saturation on r9
        IDIssue = 1'b1; IDIssueRd = 5'd9;
        repeat (3) tick();
        check("full_stall", {31'b0, IDStall}, 32'h1);
        tick();
        IDIssue = 1'b0; IDRs = 5'd9;
        WBRegWrite = 1'b1; WBRd = 5'd9; WBData = 32'h99;
        repeat (2) tick();
        WBRegWrite = 1'b0;
        #1 check("full_no_inc", {31'b0, IDStall}, 32'h1);
        WBRegWrite = 1'b1;
        tick();
        WBRegWrite = 1'b0;
        #1 check("drained", {31'b0, IDStall}, 32'h0);
        IDIssue = 1'b1;
        tick();
        WBRegWrite = 1'b1; WBData = 32'h9A;
        #1 check("inc_dec_no_stall", {31'b0, IDStall}, 32'h0);
        tick();
        IDIssue = 1'b0; WBRegWrite = 1'b0;
        #1 check("inc_dec_held", {31'b0, IDStall}, 32'h1);
        WBRegWrite = 1'b1; WBData = 32'h9B;
        tick();
        WBRegWrite = 1'b0;
        #1 check("inc_dec_drained", {31'b0, IDStall}, 32'h0);
        idle_inputs();

        // Bulk write/read sweep
        for (int i = 1; i < 32; i++) begin
            WBRegWrite = 1'b1; WBRd = 5'(i); WBData = 32'h01010101 * i;
            IDRt = 5'(i - 1);
            tick();
        end
        idle_inputs();
        IDRs = 5'd17;
        tick();
        check("sweep_r17", IDRsData, 32'h11111111);

        // Reset mid-operation
        IDIssue = 1'b1; IDIssueRd = 5'd4;
        repeat (2) tick();
        IDIssue = 1'b0; IDRs = 5'd4; IDRt = 5'd3;
        #1 check("pend4_stall", {31'b0, IDStall}, 32'h1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_rs", IDRsData, 32'h0);
        check("rst_rt", IDRtData, 32'h0);
        check("rst_stall", {31'b0, IDStall}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_stall", {31'b0, IDStall}, 32'h0);
        check("post_rst_rs", IDRsData, 32'h0);
        check("post_rst_rt", IDRtData, 32'h0);
        tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
